// File: rtl/wbm_lsu_bridge_if.sv
// LSU request/completion and Wishbone B4 pipelined bus signals seen by the bridge.
// The master modport is the bridge's view. The slave modport is the LSU/interconnect side.
interface wbm_lsu_bridge_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    localparam int SEL_W = DATA_W / 8;

    // LSU side
    logic              i_req;
    logic              i_we;
    logic [ADDR_W-1:0] i_addr;
    logic [DATA_W-1:0] i_wdata;
    logic [SEL_W-1:0]  i_sel;
    logic              o_busy;
    logic              o_done;
    logic              o_err;
    logic [DATA_W-1:0] o_rdata;

    // Wishbone side
    logic              o_wb_cyc;
    logic              o_wb_stb;
    logic              o_wb_we;
    logic [ADDR_W-1:0] o_wb_addr;
    logic [DATA_W-1:0] o_wb_data;
    logic [SEL_W-1:0]  o_wb_sel;
    logic              i_wb_ack;
    logic              i_wb_err;
    logic              i_wb_stall;
    logic [DATA_W-1:0] i_wb_data;

    modport master (
        input  i_req, i_we, i_addr, i_wdata, i_sel,
        output o_busy, o_done, o_err, o_rdata,
        output o_wb_cyc, o_wb_stb, o_wb_we, o_wb_addr, o_wb_data, o_wb_sel,
        input  i_wb_ack, i_wb_err, i_wb_stall, i_wb_data
    );

    modport slave (
        output i_req, i_we, i_addr, i_wdata, i_sel,
        input  o_busy, o_done, o_err, o_rdata,
        input  o_wb_cyc, o_wb_stb, o_wb_we, o_wb_addr, o_wb_data, o_wb_sel,
        output i_wb_ack, i_wb_err, i_wb_stall, i_wb_data
    );
endinterface

// File: rtl/wbm_lsu_bridge.sv
// Wishbone B4 pipelined master turning single LSU loads/stores into bus cycles, one in flight.
// req->done is 3 cycles plus one per stall cycle; stall holds stb, and a bus timeout aborts with err.
module wbm_lsu_bridge #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 255
) (
    input  logic             i_clk,
    input  logic             i_rst,
    wbm_lsu_bridge_if.master bus
);
    localparam int SEL_W = DATA_W / 8;
    localparam int CNT_W = $clog2(TIMEOUT + 1);
    // The counter compares against TIMEOUT-1 so that cyc is high for exactly TIMEOUT cycles.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2
    } state_t;

    state_t            state_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [CNT_W-1:0]  cnt_d;
    logic              cyc_q;
    logic              stb_q;
    logic              we_q;
    logic              busy_q;
    logic              done_q;
    logic              err_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdat_q;
    logic [DATA_W-1:0] rdata_q;
    logic [SEL_W-1:0]  sel_q;

    logic accept;
    logic resp;
    logic resp_err;
    logic expire;

    always_comb begin
        accept   = (state_q == S_REQ) && !bus.i_wb_stall;
        // A combinational slave may answer in the same cycle its strobe is accepted.
        resp     = ((state_q == S_WAIT) || accept) && (bus.i_wb_ack || bus.i_wb_err);
        resp_err = bus.i_wb_err;
        expire   = (cnt_q == CNT_LAST);
        cnt_d    = cnt_q + CNT_W'(1);
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            cyc_q   <= 1'b0;
            stb_q   <= 1'b0;
            we_q    <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            addr_q  <= '0;
            wdat_q  <= '0;
            sel_q   <= '0;
            rdata_q <= '0;
        end else begin
            done_q <= 1'b0;
            err_q  <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (bus.i_req) begin
                        we_q    <= bus.i_we;
                        addr_q  <= bus.i_addr;
                        wdat_q  <= bus.i_wdata;
                        sel_q   <= bus.i_sel;
                        cyc_q   <= 1'b1;
                        stb_q   <= 1'b1;
                        busy_q  <= 1'b1;
                        cnt_q   <= '0;
                        state_q <= S_REQ;
                    end
                end
                S_REQ, S_WAIT: begin
                    cnt_q <= cnt_d;
                    // A response on the expiry cycle takes precedence over the timeout.
                    if (resp) begin
                        cyc_q   <= 1'b0;
                        stb_q   <= 1'b0;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        err_q   <= resp_err;
                        state_q <= S_IDLE;
                        if (!resp_err && !we_q) begin
                            rdata_q <= bus.i_wb_data;
                        end
                    end else if (expire) begin
                        cyc_q   <= 1'b0;
                        stb_q   <= 1'b0;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        err_q   <= 1'b1;
                        state_q <= S_IDLE;
                    end else if (accept) begin
                        stb_q   <= 1'b0;
                        state_q <= S_WAIT;
                    end
                end
                default: begin
                    cyc_q   <= 1'b0;
                    stb_q   <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.o_busy    = busy_q;
    assign bus.o_done    = done_q;
    assign bus.o_err     = err_q;
    assign bus.o_rdata   = rdata_q;
    assign bus.o_wb_cyc  = cyc_q;
    assign bus.o_wb_stb  = stb_q;
    assign bus.o_wb_we   = we_q;
    assign bus.o_wb_addr = addr_q;
    assign bus.o_wb_data = wdat_q;
    assign bus.o_wb_sel  = sel_q;

endmodule

// File: tb/tb_wbm_lsu_bridge.sv
// Bench for wbm_lsu_bridge: directed vector table, hand-written corner sequences, then random
// transactions checked against a latency/response model derived from the bus rules.
module tb_wbm_lsu_bridge;
    localparam int ADDR_W  = 32;
    localparam int DATA_W  = 32;
    localparam int TIMEOUT = 255;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    wbm_lsu_bridge_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    wbm_lsu_bridge #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT(TIMEOUT)) dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus)
    );

    // resp: 0 = ack, 1 = err, 2 = ack+err, 3 = never answer
    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  sel;
        int          stalls;
        int          delay;
        int          resp;
        logic [31:0] rdat;
        int          exp_lat;
        logic        exp_err;
        logic [31:0] exp_rdata;
    } vec_t;

    int          checks      = 0;
    int          errors      = 0;
    int          done_pulses = 0;
    int          txn_count   = 0;
    logic [31:0] model_rdata = '0;

    always @(negedge clk) begin
        if (bus.o_done === 1'b1) done_pulses++;
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                                input logic [3:0] sel, input int stalls, input int delay,
                                input int resp, input logic [31:0] rdat, input int lat,
                                input logic err, input logic [31:0] rd);
        vec_t v;
        v.we = we; v.addr = addr; v.wdata = wdata; v.sel = sel;
        v.stalls = stalls; v.delay = delay; v.resp = resp; v.rdat = rdat;
        v.exp_lat = lat; v.exp_err = err; v.exp_rdata = rd;
        return v;
    endfunction

    // Response lands on cycle stalls+1+delay after the request; done follows one cycle later,
    // unless the bus has already been held for TIMEOUT cycles.
    task automatic model(inout vec_t v);
        int rc;
        rc = v.stalls + 1 + v.delay;
        if (v.resp == 3 || rc > TIMEOUT) begin
            v.exp_lat = TIMEOUT + 1;
            v.exp_err = 1'b1;
        end else begin
            v.exp_lat = rc + 1;
            v.exp_err = (v.resp != 0);
        end
        if (!v.exp_err && !v.we) model_rdata = v.rdat;
        v.exp_rdata = model_rdata;
    endtask

    // Called at a negedge; the request is raised immediately so it is sampled on the next edge.
    task automatic run_txn(input vec_t v, input string tag);
        int   lat      = 0;
        int   cyc_n    = 0;
        int   stb_n    = 0;
        int   busy_n   = 0;
        int   stb_seen = 0;
        int   acc      = -1;
        int   exp_stb;
        logic err_v    = 1'b0;
        logic stable   = 1'b1;
        logic [31:0] rd_v = '0;
        txn_count++;
        bus.i_req = 1'b1; bus.i_we = v.we; bus.i_addr = v.addr;
        bus.i_wdata = v.wdata; bus.i_sel = v.sel;
        for (int c = 1; c <= 400 && lat == 0; c++) begin
            @(negedge clk);
            bus.i_wb_ack = 1'b0; bus.i_wb_err = 1'b0; bus.i_wb_stall = 1'b0; bus.i_wb_data = '0;
            cyc_n  += int'(bus.o_wb_cyc);
            busy_n += int'(bus.o_busy);
            if (bus.o_done) begin
                lat = c; err_v = bus.o_err; rd_v = bus.o_rdata;
                bus.i_req = 1'b0;
            end
            if (bus.o_wb_stb) begin
                stb_n++;
                if (bus.o_wb_we !== v.we || bus.o_wb_addr !== v.addr ||
                    bus.o_wb_data !== v.wdata || bus.o_wb_sel !== v.sel) stable = 1'b0;
                if (stb_seen < v.stalls) begin
                    bus.i_wb_stall = 1'b1;
                    stb_seen++;
                end else begin
                    acc = c;
                end
            end
            if (lat == 0 && acc >= 0 && c == acc + v.delay && v.resp != 3) begin
                bus.i_wb_ack  = (v.resp == 0 || v.resp == 2);
                bus.i_wb_err  = (v.resp == 1 || v.resp == 2);
                bus.i_wb_data = v.rdat;
            end
        end
        bus.i_req = 1'b0;
        exp_stb = (v.stalls + 1 <= TIMEOUT) ? v.stalls + 1 : TIMEOUT;
        check({tag, " latency"}, 64'(lat), 64'(v.exp_lat));
        check({tag, " err"}, 64'(err_v), 64'(v.exp_err));
        check({tag, " rdata"}, 64'(rd_v), 64'(v.exp_rdata));
        check({tag, " cyc_cycles"}, 64'(cyc_n), 64'(v.exp_lat - 1));
        check({tag, " busy_cycles"}, 64'(busy_n), 64'(v.exp_lat - 1));
        check({tag, " stb_cycles"}, 64'(stb_n), 64'(exp_stb));
        check({tag, " bus_stable"}, 64'(stable), 64'd1);
    endtask

    initial begin
        vec_t tbl[10];
        vec_t v;
        int   base;
        int   r;
        bus.i_req = 1'b0; bus.i_we = 1'b0; bus.i_addr = '0; bus.i_wdata = '0; bus.i_sel = '0;
        bus.i_wb_ack = 1'b0; bus.i_wb_err = 1'b0; bus.i_wb_stall = 1'b0; bus.i_wb_data = '0;

        // Reset state
        repeat (2) @(negedge clk);
        check("rst cyc_stb", {62'd0, bus.o_wb_cyc, bus.o_wb_stb}, 64'd0);
        check("rst done_err_busy", {61'd0, bus.o_done, bus.o_err, bus.o_busy}, 64'd0);
        check("rst rdata", 64'(bus.o_rdata), 64'd0);
        check("rst bus_fields", {bus.o_wb_we, bus.o_wb_sel, bus.o_wb_addr}, 64'd0);
        rst = 1'b0;
        @(negedge clk);

        tbl[0] = mk(1'b0, 32'h2000_0004, 32'h0,    4'hF, 0, 1, 0, 32'h0000_000A, 3,   1'b0, 32'h0A);
        tbl[1] = mk(1'b1, 32'h2000_000C, 32'h55,   4'hF, 3, 1, 0, 32'hDEAD_0000, 6,   1'b0, 32'h0A);
        tbl[2] = mk(1'b0, 32'h2000_0008, 32'h0,    4'hF, 0, 1, 1, 32'h0000_0BAD, 3,   1'b1, 32'h0A);
        tbl[3] = mk(1'b0, 32'h2000_0010, 32'h0,    4'h3, 1, 2, 0, 32'h0000_1234, 5,   1'b0, 32'h1234);
        tbl[4] = mk(1'b0, 32'h2000_0014, 32'h0,    4'hF, 0, 0, 0, 32'h0000_0111, 2,   1'b0, 32'h0111);
        tbl[5] = mk(1'b0, 32'h2000_0018, 32'h0,    4'hF, 0, 0, 0, 32'h0000_0222, 2,   1'b0, 32'h0222);
        tbl[6] = mk(1'b0, 32'h2000_001C, 32'h0,    4'hF, 0, 0, 0, 32'h0000_0333, 2,   1'b0, 32'h0333);
        tbl[7] = mk(1'b0, 32'h2000_0020, 32'h0,    4'hF, 0, 1, 2, 32'h0000_0999, 3,   1'b1, 32'h0333);
        tbl[8] = mk(1'b1, 32'h2000_0024, 32'hA5A5, 4'h1, 0, 0, 1, 32'h0000_0777, 2,   1'b1, 32'h0333);
        tbl[9] = mk(1'b0, 32'h2000_0028, 32'h0,    4'hF, 0, 0, 3, 32'h0000_0888, 256, 1'b1, 32'h0333);
        for (int i = 0; i < 10; i++) begin
            run_txn(tbl[i], $sformatf("vec%0d", i));
            model_rdata = tbl[i].exp_rdata;
        end

        // Stray ack after the timeout must be dropped
        repeat (4) @(negedge clk);
        base = done_pulses;
        bus.i_wb_ack = 1'b1; bus.i_wb_data = 32'hFFFF_FFFF;
        @(negedge clk);
        bus.i_wb_ack = 1'b0; bus.i_wb_data = '0;
        repeat (3) @(negedge clk);
        check("stray_ack no_done", 64'(done_pulses - base), 64'd0);
        check("stray_ack cyc", 64'(bus.o_wb_cyc), 64'd0);
        check("stray_ack rdata", 64'(bus.o_rdata), 64'h0333);

        // Asynchronous reset in the middle of WAIT
        bus.i_req = 1'b1; bus.i_we = 1'b0; bus.i_addr = 32'h2000_0030; bus.i_sel = 4'hF;
        repeat (3) @(negedge clk);
        check("pre_rst in_wait", {62'd0, bus.o_wb_cyc, bus.o_wb_stb}, 64'd2);
        base = done_pulses;
        #2 rst = 1'b1;
        #1;
        check("async_rst cyc_stb", {62'd0, bus.o_wb_cyc, bus.o_wb_stb}, 64'd0);
        check("async_rst done_busy", {62'd0, bus.o_done, bus.o_busy}, 64'd0);
        bus.i_req = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        check("async_rst no_done", 64'(done_pulses - base), 64'd0);
        check("async_rst rdata", 64'(bus.o_rdata), 64'd0);
        model_rdata = '0;

        // Random transactions against the model
        for (int n = 0; n < 40; n++) begin
            v.we     = 1'($urandom_range(0, 1));
            v.addr   = $urandom;
            v.wdata  = $urandom;
            v.sel    = 4'($urandom_range(1, 15));
            v.stalls = $urandom_range(0, 4);
            v.delay  = $urandom_range(0, 3);
            r        = $urandom_range(0, 29);
            v.resp   = (r == 0) ? 3 : (r < 4) ? 1 : (r < 6) ? 2 : 0;
            v.rdat   = $urandom;
            model(v);
            repeat ($urandom_range(0, 2)) @(negedge clk);
            run_txn(v, $sformatf("rnd%0d", n));
        end

        repeat (4) @(negedge clk);
        check("done_pulse_total", 64'(done_pulses), 64'(txn_count));
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
